// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encodings and default widths for the SPI SCLK engine
package spi_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_WIDTH = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/spi_half_period_timer.sv
// rtl/spi_half_period_timer.sv - half-period down-counter with reload and terminal tick
module spi_half_period_timer #(
  parameter int DIV_WIDTH = spi_pkg::DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] value,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  // Tick fires on the cycle the counter sits at zero, so a period is value+1 cycles.
  assign tick = enable && (count == '0);

  // Explicit load wins; otherwise reload on tick or count down while enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load || tick) begin
      count <= value;
    end else if (enable) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/spi_sclk_engine.sv
// rtl/spi_sclk_engine.sv - SCLK generator with CPOL/CPHA modes and per-edge datapath strobes
module spi_sclk_engine #(
  parameter int DIV_WIDTH = spi_pkg::DIV_WIDTH,
  parameter int CNT_WIDTH = spi_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [CNT_WIDTH-1:0] num_bits,
  output logic                 sclk,
  output logic                 busy,
  output logic                 done,
  output logic                 load,
  output logic                 capture_edge,
  output logic                 shift_edge,
  output logic [CNT_WIDTH-1:0] bit_index
);

  import spi_pkg::*;

  logic [1:0]           state;
  logic                 cpol_q;
  logic                 cpha_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [CNT_WIDTH-1:0] bits_q;
  logic [CNT_WIDTH:0]   edge_cnt;
  logic [CNT_WIDTH:0]   next_edge;
  logic [CNT_WIDTH:0]   last_edge;
  logic                 accept;
  logic                 timer_en;
  logic                 tick;
  logic                 leading;
  logic                 is_last;
  logic                 is_first;
  logic                 is_capture;
  logic [DIV_WIDTH-1:0] timer_value;

  assign accept      = (state == ST_IDLE) && start && !abort;
  assign timer_en    = (state == ST_RUN) || (state == ST_TAIL);
  // On acceptance the timer must see the live divider, later the latched copy.
  assign timer_value = accept ? clk_div : div_q;
  assign next_edge   = edge_cnt + 1'b1;
  assign last_edge   = {bits_q, 1'b0};
  assign leading     = next_edge[0];
  assign is_last     = (next_edge == last_edge);
  assign is_first    = (next_edge == {{CNT_WIDTH{1'b0}}, 1'b1});
  assign is_capture  = cpha_q ? !leading : leading;

  spi_half_period_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .enable (timer_en),
    .value  (timer_value),
    .tick   (tick)
  );

  // Transfer FSM: edge counting, strobe decode and handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      sclk         <= 1'b0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      div_q        <= '0;
      bits_q       <= '0;
      edge_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      load         <= 1'b0;
      capture_edge <= 1'b0;
      shift_edge   <= 1'b0;
      bit_index    <= '0;
    end else begin
      load         <= 1'b0;
      done         <= 1'b0;
      capture_edge <= 1'b0;
      shift_edge   <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state <= ST_IDLE;
        sclk  <= cpol_q;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            sclk <= cpol;
            if (accept) begin
              cpol_q    <= cpol;
              cpha_q    <= cpha;
              div_q     <= clk_div;
              bits_q    <= num_bits;
              busy      <= 1'b1;
              load      <= 1'b1;
              bit_index <= '0;
              edge_cnt  <= '0;
              state     <= (num_bits == '0) ? ST_DONE : ST_RUN;
            end
          end
          ST_RUN: begin
            if (tick) begin
              sclk     <= ~sclk;
              edge_cnt <= next_edge;
              if (is_capture) begin
                capture_edge <= 1'b1;
                bit_index    <= bit_index + 1'b1;
              end else if (!(cpha_q ? is_first : is_last)) begin
                shift_edge <= 1'b1;
              end
              if (is_last) begin
                state <= ST_TAIL;
              end
            end
          end
          ST_TAIL: begin
            if (tick) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end
          end
          default: begin
            // A zero-length transfer arrives here still busy and pulses done one cycle later.
            if (busy) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule
